// File: rtl/nios2_oci_dct_packer_pkg.sv
// Shared constants and FSM encoding for the OCI DCT trace packer.
// The frame is a 2-bit header, the code count and the packed buffer.
package nios2_oci_dct_packer_pkg;
   localparam int unsigned CODE_W  = 2;
   localparam int unsigned DEPTH   = 15;
   localparam int unsigned CNT_W   = 4;
   localparam int unsigned FCNT_W  = 16;
   localparam int unsigned FRAME_W = 36;
   localparam logic [1:0]  FRAME_HDR = 2'b10;

   typedef enum logic [1:0] {
      FILL,
      FLUSH_WAIT,
      DONE
   } dct_state_e;
endpackage

// File: rtl/nios2_oci_dct_out_slot.sv
// Single-entry valid/ready output register.
// The entry holds its data while it waits for the consumer.
module nios2_oci_dct_out_slot
   import nios2_oci_dct_packer_pkg::*;
#(
   parameter int unsigned W = FRAME_W
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic [W-1:0] load_data,
   input  logic         ready,
   output logic         valid,
   output logic [W-1:0] data
);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         valid <= 1'b0;
         data  <= '0;
      end else if (load) begin
         valid <= 1'b1;
         data  <= load_data;
      end else if (ready) begin
         valid <= 1'b0;
      end
   end

endmodule

// File: rtl/nios2_oci_dct_packer.sv
// Packs 2-bit trace codes into the DCT buffer.
// Full or flushed buffers are launched as frames toward the trace RAM writer.
module nios2_oci_dct_packer #(
   parameter int unsigned CODE_W = nios2_oci_dct_packer_pkg::CODE_W,
   parameter int unsigned DEPTH  = nios2_oci_dct_packer_pkg::DEPTH,
   parameter int unsigned CNT_W  = nios2_oci_dct_packer_pkg::CNT_W,
   parameter int unsigned FCNT_W = nios2_oci_dct_packer_pkg::FCNT_W
) (
   input  logic                                      clk,
   input  logic                                      reset,
   input  logic                                      code_valid,
   input  logic [CODE_W-1:0]                         code,
   output logic                                      code_ready,
   input  logic                                      flush_req,
   input  logic                                      test_ending,
   output logic [DEPTH*CODE_W-1:0]                   dct_buffer,
   output logic [CNT_W-1:0]                          dct_count,
   output logic                                      frame_valid,
   output logic [nios2_oci_dct_packer_pkg::FRAME_W-1:0] frame_data,
   input  logic                                      frame_ready,
   output logic                                      test_has_ended,
   output logic [FCNT_W-1:0]                         frames_emitted
);
   import nios2_oci_dct_packer_pkg::*;

   localparam int unsigned BUF_W = DEPTH * CODE_W;

   dct_state_e         state, state_nx;
   logic               ended_pend, ended_pend_nx;
   logic [BUF_W-1:0]   buf_q, buf_a, buf_nx;
   logic [CNT_W-1:0]   cnt_q, cnt_a, cnt_nx;
   logic               slot_free, handshake, accept, launch;
   logic [FRAME_W-1:0] launch_data;

   assign slot_free  = !frame_valid || frame_ready;
   assign handshake  = frame_valid && frame_ready;
   assign code_ready = (state == FILL) && !ended_pend &&
                       ((cnt_q < CNT_W'(DEPTH - 1)) || slot_free);
   assign accept     = code_valid && code_ready;

   // The same-cycle code is appended before any flush decision, so a
   // flush always launches the buffer including it.
   always_comb begin
      buf_a = buf_q;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         if (accept && (cnt_q == CNT_W'(i)))
            buf_a[i*CODE_W +: CODE_W] = code;
      end
      cnt_a       = cnt_q + CNT_W'(accept);
      launch_data = {FRAME_HDR, cnt_a, buf_a};

      state_nx      = state;
      ended_pend_nx = ended_pend;
      launch        = 1'b0;

      case (state)
         FILL: begin
            if (test_ending)
               ended_pend_nx = 1'b1;
            if (cnt_a == CNT_W'(DEPTH)) begin
               launch = 1'b1;
            end else if ((flush_req || test_ending) && (cnt_a != '0)) begin
               if (slot_free)
                  launch = 1'b1;
               else
                  state_nx = FLUSH_WAIT;
            end else if ((ended_pend || test_ending) && (cnt_a == '0) && slot_free) begin
               state_nx = DONE;
            end
         end
         FLUSH_WAIT: begin
            if (test_ending)
               ended_pend_nx = 1'b1;
            if (slot_free) begin
               launch   = 1'b1;
               state_nx = FILL;
            end
         end
         DONE: ;
         default: state_nx = FILL;
      endcase

      buf_nx = launch ? '0 : buf_a;
      cnt_nx = launch ? '0 : cnt_a;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state          <= FILL;
         ended_pend     <= 1'b0;
         buf_q          <= '0;
         cnt_q          <= '0;
         frames_emitted <= '0;
      end else begin
         state      <= state_nx;
         ended_pend <= ended_pend_nx;
         buf_q      <= buf_nx;
         cnt_q      <= cnt_nx;
         if (handshake && (frames_emitted != '1))
            frames_emitted <= frames_emitted + 1'b1;
      end
   end

   assign dct_buffer     = buf_q;
   assign dct_count      = cnt_q;
   assign test_has_ended = (state == DONE);

   nios2_oci_dct_out_slot #(
      .W(FRAME_W)
   ) u_out_slot (
      .clk      (clk),
      .reset    (reset),
      .load     (launch),
      .load_data(launch_data),
      .ready    (frame_ready),
      .valid    (frame_valid),
      .data     (frame_data)
   );

endmodule

// File: tb/tb_nios2_oci_dct_packer.sv
// Directed bench for the DCT packer with a queue-based reference model
// checked every cycle, plus hand-computed frame expectations.
module tb_nios2_oci_dct_packer;

   logic        clk = 1'b0;
   logic        reset;
   logic        code_valid = 1'b0;
   logic [1:0]  code = 2'b00;
   logic        flush_req = 1'b0;
   logic        test_ending = 1'b0;
   logic        frame_ready = 1'b0;
   logic        code_ready;
   logic [29:0] dct_buffer;
   logic [3:0]  dct_count;
   logic        frame_valid;
   logic [35:0] frame_data;
   logic        test_has_ended;
   logic [15:0] frames_emitted;

   int n_checks = 0;
   int n_fail   = 0;

   nios2_oci_dct_packer dut (
      .clk           (clk),
      .reset         (reset),
      .code_valid    (code_valid),
      .code          (code),
      .code_ready    (code_ready),
      .flush_req     (flush_req),
      .test_ending   (test_ending),
      .dct_buffer    (dct_buffer),
      .dct_count     (dct_count),
      .frame_valid   (frame_valid),
      .frame_data    (frame_data),
      .frame_ready   (frame_ready),
      .test_has_ended(test_has_ended),
      .frames_emitted(frames_emitted)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   // Reference model: codes held since the last launch, plus the output slot.
   int          m_codes[$];
   bit          m_fv, m_fpend, m_endp, m_done;
   logic [35:0] m_fd;
   int unsigned m_nfr;
   bit          m_sf, m_hs, m_acc, m_launch, m_was_end;

   function automatic logic [29:0] m_buf();
      logic [29:0] b = '0;
      for (int k = 0; k < m_codes.size(); k++)
         b = b + (30'(m_codes[k]) << (2 * k));
      return b;
   endfunction

   function automatic bit m_code_ready();
      return !m_fpend && !m_endp && !m_done &&
             (m_codes.size() < 14 || !m_fv || frame_ready);
   endfunction

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_codes.delete();
         m_fv = 0; m_fpend = 0; m_endp = 0; m_done = 0;
         m_fd = '0; m_nfr = 0;
      end else begin
         m_sf  = !m_fv || frame_ready;
         m_hs  = m_fv && frame_ready;
         m_acc = code_valid && m_code_ready();
         if (m_acc) m_codes.push_back(int'(code));
         m_launch = 0;
         if (m_done) begin
         end else if (m_fpend) begin
            if (test_ending) m_endp = 1;
            if (m_sf) begin m_launch = 1; m_fpend = 0; end
         end else begin
            m_was_end = m_endp || test_ending;
            if (test_ending) m_endp = 1;
            if (m_codes.size() == 15) m_launch = 1;
            else if ((flush_req || test_ending) && m_codes.size() > 0) begin
               if (m_sf) m_launch = 1; else m_fpend = 1;
            end else if (m_was_end && m_codes.size() == 0 && m_sf) m_done = 1;
         end
         if (m_hs && m_nfr < 65535) m_nfr++;
         if (m_launch) begin
            m_fd = {2'b10, 4'(m_codes.size()), m_buf()};
            m_fv = 1;
            m_codes.delete();
         end else if (m_hs) m_fv = 0;
      end
   end

   always @(negedge clk) begin
      check("dct_count", 64'(dct_count), 64'(m_codes.size()));
      check("dct_buffer", 64'(dct_buffer), 64'(m_buf()));
      check("frame_valid", 64'(frame_valid), 64'(m_fv));
      if (m_fv) check("frame_data", 64'(frame_data), 64'(m_fd));
      check("code_ready", 64'(code_ready), 64'(m_code_ready()));
      check("test_has_ended", 64'(test_has_ended), 64'(m_done));
      check("frames_emitted", 64'(frames_emitted), 64'(m_nfr));
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input int n, input logic [1:0] c);
      code_valid = 1'b1;
      code = c;
      repeat (n) tick();
      code_valid = 1'b0;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_buffer"}, 64'(dct_buffer), 64'd0);
      check({tag, "_count"}, 64'(dct_count), 64'd0);
      check({tag, "_fvalid"}, 64'(frame_valid), 64'd0);
      check({tag, "_fdata"}, 64'(frame_data), 64'd0);
      check({tag, "_ended"}, 64'(test_has_ended), 64'd0);
      check({tag, "_frames"}, 64'(frames_emitted), 64'd0);
   endtask

   initial begin
      reset = 1'b1;
      #2 check_all_zero("rst0");
      tick(); tick();
      reset = 1'b0;

      // fifteen 2'b01 codes with the consumer ready
      frame_ready = 1'b1;
      send(15, 2'b01);
      check("t1_fv", 64'(frame_valid), 64'd1);
      check("t1_data", 64'(frame_data), 64'({2'b10, 4'hF, 30'h1555_5555}));
      check("t1_cnt", 64'(dct_count), 64'd0);
      tick();
      check("t1_fv_drop", 64'(frame_valid), 64'd0);
      check("t1_frames", 64'(frames_emitted), 64'd1);

      // codes 3,2,1 then flush
      code_valid = 1'b1;
      code = 2'd3; tick();
      code = 2'd2; tick();
      code = 2'd1; tick();
      code_valid = 1'b0;
      flush_req = 1'b1; tick(); flush_req = 1'b0;
      check("t2_fv", 64'(frame_valid), 64'd1);
      check("t2_data", 64'(frame_data), 64'({2'b10, 4'h3, 30'h0000_001B}));
      check("t2_cnt", 64'(dct_count), 64'd0);
      tick();
      check("t2_frames", 64'(frames_emitted), 64'd2);

      // stalled consumer with a full frame pending, then fourteen more codes
      frame_ready = 1'b0;
      send(15, 2'b10);
      check("t3_fv", 64'(frame_valid), 64'd1);
      code_valid = 1'b1;
      code = 2'b11;
      repeat (16) tick();
      check("t3_cnt14", 64'(dct_count), 64'd14);
      check("t3_cready", 64'(code_ready), 64'd0);
      check("t3_hold", 64'(frame_data), 64'({2'b10, 4'hF, 30'h2AAA_AAAA}));
      frame_ready = 1'b1;
      tick();
      code_valid = 1'b0;
      check("t3_data2", 64'(frame_data), 64'({2'b10, 4'hF, 30'h3FFF_FFFF}));
      check("t3_frames3", 64'(frames_emitted), 64'd3);
      tick();
      check("t3_frames4", 64'(frames_emitted), 64'd4);

      // code and flush together at count 14
      send(14, 2'b01);
      code_valid = 1'b1; code = 2'b10; flush_req = 1'b1;
      tick();
      code_valid = 1'b0; flush_req = 1'b0;
      check("t4_data", 64'(frame_data), 64'({2'b10, 4'hF, 30'h2555_5555}));
      check("t4_cnt", 64'(dct_count), 64'd0);
      tick();
      tick();
      check("t4_no_empty", 64'(frame_valid), 64'd0);
      check("t4_frames", 64'(frames_emitted), 64'd5);

      // test_ending at count 5 while a frame is stalled
      frame_ready = 1'b0;
      code_valid = 1'b1;
      code = 2'd0; tick();
      code = 2'd1; tick();
      code = 2'd2; tick();
      code = 2'd3; tick();
      code = 2'd0; tick();
      code_valid = 1'b0;
      flush_req = 1'b1; tick(); flush_req = 1'b0;
      check("t5_first", 64'(frame_data), 64'({2'b10, 4'h5, 30'h0000_00E4}));
      send(5, 2'b01);
      test_ending = 1'b1; tick(); test_ending = 1'b0;
      code_valid = 1'b1; code = 2'b11;
      for (int i = 0; i < 4; i++) begin
         tick();
         check("t5_wait_cready", 64'(code_ready), 64'd0);
         check("t5_wait_cnt", 64'(dct_count), 64'd5);
         check("t5_wait_hold", 64'(frame_data), 64'({2'b10, 4'h5, 30'h0000_00E4}));
      end
      frame_ready = 1'b1;
      tick();
      check("t5_final", 64'(frame_data), 64'({2'b10, 4'h5, 30'h0000_0155}));
      check("t5_frames6", 64'(frames_emitted), 64'd6);
      tick();
      check("t5_ended", 64'(test_has_ended), 64'd1);
      check("t5_frames7", 64'(frames_emitted), 64'd7);
      tick();
      check("t5_done_cready", 64'(code_ready), 64'd0);
      check("t5_done_cnt", 64'(dct_count), 64'd0);
      code_valid = 1'b0;

      // reset while a frame is outstanding and a flush is waiting
      reset = 1'b1; tick(); reset = 1'b0;
      frame_ready = 1'b0;
      send(3, 2'b10);
      flush_req = 1'b1; tick(); flush_req = 1'b0;
      send(2, 2'b01);
      flush_req = 1'b1; tick(); flush_req = 1'b0;
      check("t6_wait_cready", 64'(code_ready), 64'd0);
      check("t6_wait_fv", 64'(frame_valid), 64'd1);
      #2 reset = 1'b1;
      #1 check_all_zero("t6_rst");
      tick();
      reset = 1'b0;
      frame_ready = 1'b1;
      send(15, 2'b11);
      check("t6_data", 64'(frame_data), 64'({2'b10, 4'hF, 30'h3FFF_FFFF}));
      tick();
      check("t6_frames", 64'(frames_emitted), 64'd1);

      repeat (2) tick();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
